// File: rtl/alu_pkg.sv
// alu_pkg: op encodings and sequencer state type shared with the ALU datapath
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, ITER = 2'b10, FIN = 2'b11} state_t;
endpackage

// File: rtl/iter_counter.sv
// iter_counter: loadable down-counter with zero flag that saturates at 0
module iter_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] init,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else if (load) count <= init;
    else if (dec && count != '0) count <= count - 1'b1;
  end
  assign zero = count == '0;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: control FSM sequencing single-cycle ADD/SUB and iterative MUL/DIV
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MUL_CYCLES = WIDTH,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op_sel,
  input  logic       div_zero,
  output logic [1:0] alu_op,
  output logic       step,
  output logic       load_alu,
  output logic       busy,
  output logic       done,
  output logic       error
);
  localparam int N_MAX = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(N_MAX + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_INIT = CW'(DIV_CYCLES - 1);
  state_t state, state_nxt;
  logic accept, div_abort, cnt_zero;
  assign accept    = state == IDLE && start;
  assign div_abort = op_sel == OP_DIV && div_zero;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !start ? IDLE : !op_sel[1] ? EXEC : div_abort ? FIN : ITER;
      EXEC:    state_nxt = FIN;
      ITER:    state_nxt = cnt_zero ? FIN : ITER;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      alu_op <= OP_ADD;
      error  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_op <= op_sel;
        error  <= div_abort;
      end
    end
  end
  iter_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept && op_sel[1] && !div_abort),
    .dec   (state == ITER),
    .init  (op_sel == OP_DIV ? DIV_INIT : MUL_INIT),
    .zero  (cnt_zero)
  );
  // last iteration doubles as the result-register load
  assign step     = state == ITER;
  assign load_alu = state == EXEC || (state == ITER && cnt_zero);
  assign done     = state == FIN;
  assign busy     = state != IDLE;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table-driven check of a default and a MUL=1/DIV=16 sequencer side by side
module tb_alu_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, div_zero = 1'b0;
  logic [1:0] op_sel = 2'b00;
  logic [1:0] ao0, ao1;
  logic step0, step1, ld0, ld1, bz0, bz1, dn0, dn1, er0, er1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_sequencer #(.WIDTH(8)) u0 (
    .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .div_zero(div_zero),
    .alu_op(ao0), .step(step0), .load_alu(ld0), .busy(bz0), .done(dn0), .error(er0));
  alu_sequencer #(.WIDTH(8), .MUL_CYCLES(1), .DIV_CYCLES(16)) u1 (
    .clk(clk), .reset(reset), .start(start), .op_sel(op_sel), .div_zero(div_zero),
    .alu_op(ao1), .step(step1), .load_alu(ld1), .busy(bz1), .done(dn1), .error(er1));
  logic [1:0] st, ld, dn, bz, er;
  logic [3:0] aov;
  assign st = {step1, step0};
  assign ld = {ld1, ld0};
  assign dn = {dn1, dn0};
  assign bz = {bz1, bz0};
  assign er = {er1, er0};
  assign aov = {ao1, ao0};
  typedef struct {
    logic [1:0] op;
    logic dz;
    int s0, s1, l0, l1, d0, d1;
    logic e;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic run_check(input vec_t v, input string tag);
    int ns[2], lc[2], lcnt[2], dc[2], dcnt[2], lstep[2], bad_bz[2], ovl[2], ed[2], ee[2], aop[2];
    int es[2], el[2], ed_c[2];
    es = '{v.s0, v.s1};
    el = '{v.l0, v.l1};
    ed_c = '{v.d0, v.d1};
    for (int d = 0; d < 2; d++) begin
      ns[d] = 0; lc[d] = -1; lcnt[d] = 0; dc[d] = -1; dcnt[d] = 0; lstep[d] = -1;
      bad_bz[d] = 0; ovl[d] = 0; ed[d] = -1; aop[d] = -1;
    end
    @(negedge clk);
    start = 1'b1; op_sel = v.op; div_zero = v.dz;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; op_sel = ~v.op; div_zero = ~v.dz; end
      for (int d = 0; d < 2; d++) begin
        if (st[d]) begin ns[d]++; lstep[d] = k; end
        if (ld[d]) begin lcnt[d]++; lc[d] = k; end
        if (dn[d]) begin dcnt[d]++; dc[d] = k; ed[d] = int'(er[d]); end
        if (ld[d] && dn[d]) ovl[d]++;
        if (bz[d] !== (k <= ed_c[d])) bad_bz[d]++;
        if (k == 1) aop[d] = int'(aov[2*d +: 2]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      ee[d] = int'(er[d]);
      chk($sformatf("%s dut%0d steps", tag, d), ns[d], es[d]);
      chk($sformatf("%s dut%0d last_step", tag, d), lstep[d], es[d] > 0 ? el[d] : -1);
      chk($sformatf("%s dut%0d load_cycle", tag, d), lc[d], el[d]);
      chk($sformatf("%s dut%0d load_count", tag, d), lcnt[d], el[d] < 0 ? 0 : 1);
      chk($sformatf("%s dut%0d done_cycle", tag, d), dc[d], ed_c[d]);
      chk($sformatf("%s dut%0d done_count", tag, d), dcnt[d], 1);
      chk($sformatf("%s dut%0d err_at_done", tag, d), ed[d], int'(v.e));
      chk($sformatf("%s dut%0d err_held", tag, d), ee[d], int'(v.e));
      chk($sformatf("%s dut%0d alu_op", tag, d), aop[d], int'(v.op));
      chk($sformatf("%s dut%0d busy_window", tag, d), bad_bz[d], 0);
      chk($sformatf("%s dut%0d load_done_overlap", tag, d), ovl[d], 0);
    end
    op_sel = 2'b00; div_zero = 1'b0;
  endtask
  initial begin
    int ns0, ns1, dc0, dc1, dcnt;
    tbl[0] = '{2'b00, 1'b0, 0, 0, 1, 1, 2, 2, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 0, 0, 1, 1, 2, 2, 1'b0};
    tbl[2] = '{2'b10, 1'b0, 8, 1, 8, 1, 9, 2, 1'b0};
    tbl[3] = '{2'b11, 1'b0, 8, 16, 8, 16, 9, 17, 1'b0};
    tbl[4] = '{2'b11, 1'b1, 0, 0, -1, -1, 1, 1, 1'b1};
    tbl[5] = '{2'b00, 1'b0, 0, 0, 1, 1, 2, 2, 1'b0};
    tbl[6] = '{2'b10, 1'b1, 8, 1, 8, 1, 9, 2, 1'b0};
    tbl[7] = '{2'b01, 1'b0, 0, 0, 1, 1, 2, 2, 1'b0};
    #12;
    chk("reset outputs dut0", int'({ao0, step0, ld0, bz0, dn0, er0}), 0);
    chk("reset outputs dut1", int'({ao1, step1, ld1, bz1, dn1, er1}), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) run_check(tbl[i], $sformatf("vec%0d", i));
    // start pulsed mid-DIV must be ignored
    @(negedge clk);
    start = 1'b1; op_sel = 2'b11; div_zero = 1'b0;
    ns0 = 0; ns1 = 0; dc0 = -1; dc1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin start = 1'b1; op_sel = 2'b00; div_zero = 1'b1; end
      if (k == 3) begin start = 1'b0; div_zero = 1'b0; end
      if (step0) ns0++;
      if (step1) ns1++;
      if (dn0) dc0 = k;
      if (dn1) dc1 = k;
    end
    chk("collision dut0 steps", ns0, 8);
    chk("collision dut1 steps", ns1, 16);
    chk("collision dut0 done_cycle", dc0, 9);
    chk("collision dut1 done_cycle", dc1, 17);
    chk("collision alu_op", int'({ao1, ao0}), 4'b1111);
    chk("collision error", int'({er1, er0}), 0);
    // start raised during FIN is not an accept
    @(negedge clk);
    start = 1'b1; op_sel = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin start = 1'b1; op_sel = 2'b10; end
      if (k == 3) begin
        start = 1'b0;
        chk("fin_start busy", int'(bz0), 0);
      end
      if (k == 4) chk("fin_start idle", int'({bz0, step0, ao0}), 0);
    end
    // asynchronous reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; op_sel = 2'b10;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    chk("pre_reset step", int'(step0), 1);
    #1 reset = 1'b1;
    #1 chk("async reset outputs", int'({ao0, step0, ld0, bz0, dn0, er0}), 0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dn0 || ld0 || dn1 || ld1) dcnt++;
    end
    chk("no strobes after reset", dcnt, 0);
    run_check(tbl[1], "post_reset_sub");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
